// File: rtl/i2c_init_seq.sv
// Table-driven I2C init sequencer: fetches 26-bit commands from a ROM port and
// drives an i2c_master with writes, read-back verifies and timed delays.
module i2c_init_seq #(
  parameter logic [6:0]  CHIP_ADDR   = 7'h39,
  parameter int unsigned CMD_COUNT   = 32,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned DELAY_UNIT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] cmd_addr,
  input  logic [25:0]      cmd_data,
  output logic [6:0]       i2c_chip_addr,
  output logic [7:0]       i2c_reg_addr,
  output logic [7:0]       i2c_wdata,
  output logic             i2c_write_en,
  output logic             i2c_read_en,
  input  logic [7:0]       i2c_rdata,
  input  logic             i2c_done,
  input  logic [2:0]       i2c_status,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [1:0]       err_code
);

  localparam int unsigned UNIT_W  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam int unsigned RETRY_W = 4;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(CMD_COUNT - 1);
  localparam logic [UNIT_W-1:0]  UNIT_RELOAD = UNIT_W'(DELAY_UNIT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {OP_WRITE, OP_VERIFY, OP_DELAY, OP_END} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         mask_q, mask_d;
  logic [15:0]        tick_q, tick_d;
  logic [UNIT_W-1:0]  unit_q, unit_d;

  logic [IDX_W-1:0]   cmd_addr_d, err_index_d;
  logic [7:0]         reg_addr_d, wdata_d;
  logic               write_en_d, read_en_d, busy_d, done_d, error_d;
  logic [1:0]         err_code_d;
  logic               adv, fail;
  logic [1:0]         fail_code;

  assign i2c_chip_addr = CHIP_ADDR;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      index_q      <= '0;
      retry_q      <= '0;
      mask_q       <= '0;
      tick_q       <= '0;
      unit_q       <= '0;
      cmd_addr     <= '0;
      i2c_reg_addr <= '0;
      i2c_wdata    <= '0;
      i2c_write_en <= 1'b0;
      i2c_read_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
      err_code     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      mask_q       <= mask_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
      cmd_addr     <= cmd_addr_d;
      i2c_reg_addr <= reg_addr_d;
      i2c_wdata    <= wdata_d;
      i2c_write_en <= write_en_d;
      i2c_read_en  <= read_en_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      err_index    <= err_index_d;
      err_code     <= err_code_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    retry_d     = retry_q;
    mask_d      = mask_q;
    tick_d      = tick_q;
    unit_d      = unit_q;
    cmd_addr_d  = cmd_addr;
    reg_addr_d  = i2c_reg_addr;
    wdata_d     = i2c_wdata;
    write_en_d  = 1'b0;
    read_en_d   = 1'b0;
    busy_d      = busy;
    done_d      = done;
    error_d     = error;
    err_index_d = err_index;
    err_code_d  = err_code;
    adv         = 1'b0;
    fail        = 1'b0;
    fail_code   = 2'd0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_FETCH;
          index_d    = '0;
          retry_d    = '0;
          cmd_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = op_t'(cmd_data[25:24]);
        mask_d = cmd_data[7:0];
        case (op_t'(cmd_data[25:24]))
          OP_WRITE, OP_VERIFY: begin
            reg_addr_d = cmd_data[23:16];
            wdata_d    = cmd_data[15:8];
            write_en_d = (cmd_data[25:24] == 2'd0);
            read_en_d  = (cmd_data[25:24] == 2'd1);
            state_d    = S_ISSUE;
          end
          OP_DELAY: begin
            if (cmd_data[15:0] != 16'd0) begin
              tick_d  = cmd_data[15:0] - 16'd1;
              unit_d  = UNIT_RELOAD;
              state_d = S_DELAY;
            end else begin
              adv = 1'b1;
            end
          end
          default: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_status != 3'd0) begin
            if (retry_q != RETRY_LIMIT) begin
              retry_d    = retry_q + RETRY_W'(1);
              write_en_d = (op_q == OP_WRITE);
              read_en_d  = (op_q == OP_VERIFY);
              state_d    = S_ISSUE;
            end else begin
              fail      = 1'b1;
              fail_code = 2'd1;
            end
          end else if (op_q == OP_VERIFY &&
                       (i2c_rdata & mask_q) != (i2c_wdata & mask_q)) begin
            fail      = 1'b1;
            fail_code = 2'd2;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DELAY: begin
        // Two-level countdown: unit cycles per tick, tick count from the command
        if (unit_q != '0) begin
          unit_d = unit_q - UNIT_W'(1);
        end else if (tick_q != 16'd0) begin
          tick_d = tick_q - 16'd1;
          unit_d = UNIT_RELOAD;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      retry_d = '0;
      if (index_q == LAST_IDX) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        index_d    = index_q + IDX_W'(1);
        cmd_addr_d = index_q + IDX_W'(1);
        state_d    = S_FETCH;
      end
    end

    if (fail) begin
      state_d     = S_ERROR;
      error_d     = 1'b1;
      busy_d      = 1'b0;
      err_index_d = index_q;
      err_code_d  = fail_code;
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: ROM and i2c_master models, directed sequences, a
// verify vector table and randomized command tables checked against a model.
`timescale 1ns/1ps
module tb_i2c_init_seq;
  localparam int unsigned CMD_COUNT   = 6;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned MAX_RETRIES = 2;
  localparam int unsigned DELAY_UNIT  = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] cmd_addr;
  logic [25:0]      cmd_data = '0;
  logic [6:0]       i2c_chip_addr;
  logic [7:0]       i2c_reg_addr, i2c_wdata;
  logic             i2c_write_en, i2c_read_en;
  logic [7:0]       i2c_rdata = '0;
  logic             i2c_done = 1'b0;
  logic [2:0]       i2c_status = '0;
  logic             busy, done, error;
  logic [IDX_W-1:0] err_index;
  logic [1:0]       err_code;

  i2c_init_seq #(.CHIP_ADDR(7'h39), .CMD_COUNT(CMD_COUNT), .IDX_W(IDX_W),
                 .MAX_RETRIES(MAX_RETRIES), .DELAY_UNIT(DELAY_UNIT)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .i2c_chip_addr(i2c_chip_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
    .i2c_write_en(i2c_write_en), .i2c_read_en(i2c_read_en), .i2c_rdata(i2c_rdata),
    .i2c_done(i2c_done), .i2c_status(i2c_status), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .err_code(err_code));

  always #5 clk = ~clk;

  typedef struct { bit is_rd; logic [7:0] rg; logic [7:0] dat; int cyc; } req_t;
  typedef struct { logic [7:0] rdata; logic [7:0] data; logic [7:0] mask; bit exp_err; } vec_t;

  int n_checks = 0, n_pass = 0, mon_err = 0, cyc = 0;
  logic [25:0] rom [0:15];
  logic [7:0]  rd_mem [0:255];
  logic [2:0]  resp_s [0:63];
  int          resp_l [0:63];
  int          resp_ptr = 0;
  req_t        req_q[$];
  int          done_q[$];
  int          last_scyc, last_bcyc;

  // Registered ROM: data follows the address by one cycle
  always @(posedge clk) cmd_data <= rom[cmd_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_fail(input string what);
    mon_err++;
    if (mon_err <= 10) $display("FAIL monitor_%s: got violation at cycle %0d, required none", what, cyc);
  endtask

  // i2c_master model, driven mid-cycle; responses come from resp_s/resp_l
  bit         m_busy = 0, prev_req = 0, m_rd = 0;
  int         m_cnt = 0;
  logic [7:0] m_reg = '0, m_dat = '0;
  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_cnt = 0; prev_req = 0; i2c_done = 1'b0; i2c_status = '0;
    end else begin
      i2c_done   = 1'b0;
      i2c_status = 3'($urandom);
      i2c_rdata  = 8'($urandom);
      if (done && error) mon_fail("done_and_error");
      if (i2c_write_en || i2c_read_en) begin
        if (m_busy) mon_fail("overlap");
        if (i2c_write_en && i2c_read_en) mon_fail("both_req");
        if (prev_req) mon_fail("pulse_width");
        if (i2c_chip_addr != 7'h39) mon_fail("chip_addr");
        req_q.push_back('{i2c_read_en, i2c_reg_addr, i2c_wdata, cyc});
        m_busy = 1; m_rd = i2c_read_en; m_reg = i2c_reg_addr; m_dat = i2c_wdata;
        m_cnt = (resp_ptr < 64) ? resp_l[resp_ptr] : 1;
      end else if (m_busy) begin
        if (i2c_reg_addr != m_reg || (!m_rd && i2c_wdata != m_dat)) mon_fail("stable");
        m_cnt--;
        if (m_cnt <= 0) begin
          i2c_done   = 1'b1;
          i2c_status = (resp_ptr < 64) ? resp_s[resp_ptr] : 3'd0;
          i2c_rdata  = rd_mem[m_reg];
          resp_ptr++;
          done_q.push_back(cyc);
          m_busy = 0;
        end
      end
      prev_req = i2c_write_en || i2c_read_en;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [25:0] w_wr(input logic [7:0] r, input logic [7:0] d);
    return {2'd0, r, d, 8'h00};
  endfunction
  function automatic logic [25:0] w_vf(input logic [7:0] r, input logic [7:0] d, input logic [7:0] m);
    return {2'd1, r, d, m};
  endfunction
  function automatic logic [25:0] w_dl(input logic [15:0] k);
    return {2'd2, 8'h00, k};
  endfunction
  function automatic logic [25:0] w_end();
    return {2'd3, 24'h0};
  endfunction

  task automatic set_resp_ok(input int lat);
    for (int k = 0; k < 64; k++) begin resp_s[k] = 3'd0; resp_l[k] = lat; end
  endtask

  // Reference: walk the command list with the scripted bus responses
  req_t exp_q[$];
  task automatic model(output bit m_done, output bit m_err, output int m_idx,
                       output int m_code, output int m_busy_cyc);
    int k = 0, idx = 0;
    m_done = 0; m_err = 0; m_idx = 0; m_code = 0; m_busy_cyc = 0;
    exp_q.delete();
    while (!m_done && !m_err) begin
      logic [25:0] w;
      if (idx == int'(CMD_COUNT)) begin m_done = 1; break; end
      w = rom[idx];
      m_busy_cyc += 2;
      if (w[25:24] == 2'd0 || w[25:24] == 2'd1) begin
        int tries = 0;
        while (1) begin
          logic [2:0] st;
          exp_q.push_back('{w[25:24] == 2'd1, w[23:16], w[15:8], 0});
          m_busy_cyc += 1 + resp_l[k];
          st = resp_s[k];
          k++;
          if (st != 3'd0) begin
            if (tries == int'(MAX_RETRIES)) begin m_err = 1; m_code = 1; break; end
            tries++;
          end else begin
            if (w[25:24] == 2'd1 && ((rd_mem[w[23:16]] & w[7:0]) != (w[15:8] & w[7:0]))) begin
              m_err = 1; m_code = 2;
            end
            break;
          end
        end
      end else if (w[25:24] == 2'd2) begin
        m_busy_cyc += int'(w[15:0]) * int'(DELAY_UNIT);
      end else begin
        m_done = 1;
      end
      if (m_err) m_idx = idx;
      else if (!m_done) idx++;
    end
  endtask

  task automatic run_seq(input bit rnd_start, output int bcyc, output int scyc, output bit tmo);
    req_q.delete(); done_q.delete(); resp_ptr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    scyc = cyc; bcyc = 0; tmo = 1;
    for (int i = 0; i < 5000; i++) begin
      if (!busy) begin tmo = 0; break; end
      bcyc++;
      start = rnd_start && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_and_model(input string name, input bit rnd);
    bit m_done, m_err, tmo;
    int m_idx, m_code, m_busy_cyc, bcyc, scyc, bad;
    model(m_done, m_err, m_idx, m_code, m_busy_cyc);
    run_seq(rnd, bcyc, scyc, tmo);
    last_scyc = scyc; last_bcyc = bcyc;
    check({name, "_timeout"}, tmo, 0);
    check({name, "_done"}, done, m_done);
    check({name, "_error"}, error, m_err);
    check({name, "_err_code"}, err_code, m_err ? m_code : 0);
    if (m_err) check({name, "_err_index"}, err_index, m_idx);
    check({name, "_busy_cycles"}, bcyc, m_busy_cyc);
    check({name, "_req_count"}, req_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < req_q.size() && i < exp_q.size(); i++)
      if (req_q[i].is_rd != exp_q[i].is_rd || req_q[i].rg != exp_q[i].rg ||
          (!exp_q[i].is_rd && req_q[i].dat != exp_q[i].dat)) bad++;
    check({name, "_req_content_mismatches"}, bad, 0);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_cmd_addr"}, cmd_addr, 0);
    check({p, "_reg_addr"}, i2c_reg_addr, 0);
    check({p, "_wdata"}, i2c_wdata, 0);
    check({p, "_req_pulses"}, {i2c_write_en, i2c_read_en}, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done_error"}, {done, error}, 0);
    check({p, "_err_index"}, err_index, 0);
    check({p, "_err_code"}, err_code, 0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{8'h5A, 8'h50, 8'hF0, 1'b0};
    vecs[1] = '{8'h60, 8'h50, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h81, 8'h01, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h01, 1'b1};
    vecs[5] = '{8'hAB, 8'hAB, 8'hFF, 1'b0};
    vecs[6] = '{8'hAA, 8'hAB, 8'hFF, 1'b1};
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) rom[i] = w_end();
    set_resp_ok(2);

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check("chip_addr", i2c_chip_addr, 7'h39);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Six writes run off the end of the table
    for (int i = 0; i < 6; i++) rom[i] = w_wr(8'h10 + 8'(i), 8'hA0 + 8'(i));
    set_resp_ok(1);
    run_and_model("writes", 0);
    check("writes_count", req_q.size(), 6);
    if (req_q.size() == 6) begin
      check("writes_first_latency", req_q[0].cyc, last_scyc + 2);
      check("writes_last_data", req_q[5].dat, 8'hA5);
    end
    check("writes_done_busy", {done, busy, error}, 3'b100);

    // Index 1 NACKed twice, then accepted
    rom[0] = w_wr(8'h30, 8'hC0); rom[1] = w_wr(8'h31, 8'hC1); rom[2] = w_end();
    set_resp_ok(2); resp_s[1] = 3'd3; resp_s[2] = 3'd1;
    run_and_model("retry_ok", 0);
    check("retry_ok_count", req_q.size(), 4);
    if (req_q.size() == 4 && done_q.size() >= 3) begin
      check("retry_ok_reg", req_q[3].rg, 8'h31);
      check("retry_ok_gap1", req_q[2].cyc, done_q[1] + 1);
      check("retry_ok_gap2", req_q[3].cyc, done_q[2] + 1);
    end
    check("retry_ok_done", done, 1);

    // Index 5 never acknowledged
    for (int i = 0; i < 6; i++) rom[i] = w_wr(8'h50 + 8'(i), 8'h5 + 8'(i));
    set_resp_ok(1);
    for (int k = 5; k < 64; k++) resp_s[k] = 3'd2;
    run_and_model("retry_fail", 0);
    repeat (20) @(negedge clk);
    check("retry_fail_count", req_q.size(), 8);
    check("retry_fail_error", {error, done}, 2'b10);
    check("retry_fail_err_index", err_index, 5);
    check("retry_fail_err_code", err_code, 1);

    // DELAY 3 ticks, zero-tick DELAY, END before CMD_COUNT
    rom[0] = w_dl(16'd3); rom[1] = w_dl(16'd0); rom[2] = w_end(); rom[3] = w_wr(8'h77, 8'h77);
    set_resp_ok(1);
    run_and_model("delay", 0);
    check("delay_busy_cycles", last_bcyc, 36);
    check("delay_no_requests", req_q.size(), 0);
    check("delay_done", {done, error}, 2'b10);

    // Verify vector table
    set_resp_ok(2);
    for (int v = 0; v < 7; v++) begin
      rom[0] = w_vf(8'h42, vecs[v].data, vecs[v].mask); rom[1] = w_end();
      rd_mem[8'h42] = vecs[v].rdata;
      run_and_model($sformatf("verify%0d", v), 0);
      check($sformatf("verify%0d_error", v), error, vecs[v].exp_err);
      check($sformatf("verify%0d_code", v), err_code, vecs[v].exp_err ? 2 : 0);
      check($sformatf("verify%0d_no_retry", v), req_q.size(), 1);
    end

    // Randomized tables; runs restart straight from DONE/ERROR
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        int p = $urandom_range(0, 99);
        logic [7:0] rg = 8'($urandom), mk = 8'($urandom);
        if (p < 45) rom[i] = w_wr(rg, 8'($urandom));
        else if (p < 75) rom[i] = w_vf(rg, rd_mem[rg] ^ (($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00), mk);
        else if (p < 93) rom[i] = w_dl(16'($urandom_range(0, 2)));
        else rom[i] = w_end();
      end
      for (int k = 0; k < 64; k++) begin
        resp_s[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        resp_l[k] = $urandom_range(1, 3);
      end
      run_and_model($sformatf("rand%0d", r), 1);
    end

    // Asynchronous reset while waiting on the bus, then restart
    rom[0] = w_wr(8'h11, 8'hA1); rom[1] = w_wr(8'h12, 8'hA2); rom[2] = w_end();
    set_resp_ok(8);
    req_q.delete(); resp_ptr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && req_q.size() == 0; i++) @(negedge clk);
    check("rst_wait_reached", req_q.size(), 1);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    set_resp_ok(2);
    run_and_model("after_reset", 0);
    if (req_q.size() > 0) check("after_reset_first_reg", req_q[0].rg, 8'h11);

    check("monitor_violations", mon_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_init_seq.md
# i2c_init_seq

Parametrised, table-driven I2C initialisation sequencer. It replaces hard-coded per-chip init state machines with a command list fetched from an external ROM port. It supports register writes, read-back verification, timed delays and early termination, with bounded retries on bus errors and a sticky error report. It sits between the system start/reset logic and the existing `i2c_master` (1-byte address, 1-byte data), driving that master's request/response pins directly.

## Interface

**Parameters**
- `CHIP_ADDR`, default 7'h39: 7-bit target address placed on `i2c_chip_addr` for every transaction.
- `CMD_COUNT`, default 32: number of table entries (1..256). Reaching this count ends the sequence.
- `IDX_W`, default 8: width of the command index, `cmd_addr` and `err_index`. Must satisfy 2^IDX_W ≥ CMD_COUNT.
- `MAX_RETRIES`, default 3: re-issues allowed per command on a nonzero `i2c_status` (0..15).
- `DELAY_UNIT`, default 1000: clock cycles per delay tick (≥1).

**Ports**
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin sequence. Sampled only in IDLE, DONE or ERROR.
- `cmd_addr` out IDX_W: ROM read address.
- `cmd_data` in 26: ROM word. Valid exactly 1 cycle after `cmd_addr` changes.
- `i2c_chip_addr` out 7: always `CHIP_ADDR`.
- `i2c_reg_addr` out 8: register address.
- `i2c_wdata` out 8: write data.
- `i2c_write_en` out 1: one-cycle write request pulse.
- `i2c_read_en` out 1: one-cycle read request pulse.
- `i2c_rdata` in 8: read data, valid with `i2c_done`.
- `i2c_done` in 1: one-cycle completion pulse.
- `i2c_status` in 3: completion status. 0 = OK; nonzero = NACK or arbitration loss.
- `busy` out 1: high from the cycle after an accepted `start` until DONE or ERROR.
- `done` out 1: sticky; sequence finished without error.
- `error` out 1: sticky; sequence aborted.
- `err_index` out IDX_W: index of the failing command. Valid while `error` is high.
- `err_code` out 2: 1 = retries exhausted; 2 = verify mismatch; 0 = none.

## Operation

**Command word**
- Bits [25:24] = opcode; [23:16] = reg; [15:8] = data; [7:0] = mask.
- Opcode 0, WRITE: write `data` to `reg`.
- Opcode 1, VERIFY: read `reg`; pass if `(rdata & mask) == (data & mask)`.
- Opcode 2, DELAY: wait `cmd[15:0] × DELAY_UNIT` cycles. A count of 0 means no wait.
- Opcode 3, END: terminate with success immediately.

**States:** IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE, ERROR.

**Transitions**
- IDLE/DONE/ERROR with `start` → FETCH. On this transition: index=0, retry=0, `done`/`error`/`err_code` cleared.
- FETCH: drive `cmd_addr`=index → DECODE.
- DECODE: latch `cmd_data`, then branch:
  - WRITE or VERIFY → ISSUE.
  - DELAY with count>0 → DELAY.
  - DELAY with count=0 → advance.
  - END → DONE.
- ISSUE: pulse `i2c_write_en` (WRITE) or `i2c_read_en` (VERIFY) for exactly one cycle; reg/wdata stable from this cycle until `i2c_done` → WAIT.
- WAIT: ignore all inputs except `i2c_done`. On `i2c_done`:
  - status≠0 and retry<MAX_RETRIES → retry+1, go to ISSUE.
  - status≠0 and retry=MAX_RETRIES → ERROR, err_code=1.
  - status=0, VERIFY fails → ERROR, err_code=2. Mismatches are not retried.
  - status=0 otherwise → advance.
- DELAY: count down; on terminal count → advance.
- Advance: index+1, retry=0. If the new index equals CMD_COUNT → DONE, else → FETCH.
- ERROR: latch `err_index`=index.

**Other rules**
- `i2c_busy` is not consulted. The master must accept a request whenever it is idle, and this block issues a request only after the prior `i2c_done`.
- `start` in FETCH..DELAY is ignored.
- `start` in DONE/ERROR restarts from index 0.
- Index arithmetic is IDX_W wide. No wrap-around is possible, because the index terminates at CMD_COUNT.

**Reset (asynchronous)**
- Returns to IDLE from any state, including mid-transaction.
- Reset values: `cmd_addr`=0, `i2c_reg_addr`=0, `i2c_wdata`=0, `i2c_write_en`=0, `i2c_read_en`=0, `busy`=0, `done`=0, `error`=0, `err_index`=0, `err_code`=0.
- The master is reset by the same signal.

## Timing

- All outputs are registered.
- `start` sampled at edge 0: FETCH at 1 (`cmd_addr` valid), DECODE at 2 (samples `cmd_data`), `i2c_write_en`/`i2c_read_en` high during cycle 3, WAIT from 4.
- `i2c_done` at edge N: with a pass, FETCH of the next index at N+1; with a retry, ISSUE pulse at N+1.
- Per-command overhead beyond bus time: 3 cycles for WRITE/VERIFY.
- DELAY of k ticks occupies exactly k×DELAY_UNIT cycles in DELAY, plus 2 cycles of FETCH/DECODE.
- `busy` rises 1 cycle after `start` is accepted. `busy` falls, and `done`/`error` rise, in the same cycle.
- `done` and `error` are never both high.

## Test plan

- **Three WRITEs, then CMD_COUNT=3**, master returns status 0 → exactly 3 write pulses with reg/wdata matching the table, `done`=1, `busy`=0, `error`=0.
- **WRITE NACKed twice then OK**, MAX_RETRIES=3 → 3 `i2c_write_en` pulses for that index, each 1 cycle after `i2c_done`; sequence completes with `done`=1.
- **WRITE at index 5 always NACKed**, MAX_RETRIES=2 → 3 pulses, then `error`=1, `err_index`=5, `err_code`=1; no further requests.
- **VERIFY reg 0x42, data 0x50, mask 0xF0**:
  - `i2c_rdata`=0x5A → pass, index advances.
  - `i2c_rdata`=0x60 → `error`=1, `err_code`=2, no retry.
- **DELAY count 3, DELAY_UNIT=10**, followed by END at index 2 → 30 cycles with no I2C requests, then `done`=1 with CMD_COUNT unreached.
- **Reset asserted during WAIT**, then `start` after release → all outputs at reset values asynchronously; restart issues index 0 again.
